// File: rtl/muldiv_pkg.sv
// Shared constants, op encodings and FSM state type for the HI/LO muldiv sequencer.
package muldiv_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 5;

    localparam logic [1:0] OP_DIV   = 2'b00;
    localparam logic [1:0] OP_DIVU  = 2'b01;
    localparam logic [1:0] OP_MULT  = 2'b10;
    localparam logic [1:0] OP_MULTU = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ZERO = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } muldiv_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: restoring-divide step or shift-add multiply step.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic [W-1:0] part,
    input  logic [W-1:0] shq,
    input  logic [W-1:0] opnd,
    input  logic         mul_mode,
    output logic [W-1:0] part_nx,
    output logic [W-1:0] shq_nx
);

    logic [W:0] shifted;
    logic [W:0] diff;
    logic [W:0] sum;

    always_comb begin
        // divide: 33-bit partial remainder, quotient bits shift in at shq[0]
        shifted = {part, shq[W-1]};
        diff    = shifted - {1'b0, opnd};
        // multiply: {part, shq} is the running product, multiplier leaves at shq[0]
        sum     = {1'b0, part} + (shq[0] ? {1'b0, opnd} : '0);
        if (mul_mode) begin
            part_nx = sum[W:1];
            shq_nx  = {sum[0], shq[W-1:1]};
        end else if (!diff[W]) begin
            part_nx = diff[W-1:0];
            shq_nx  = {shq[W-2:0], 1'b1};
        end else begin
            part_nx = shifted[W-1:0];
            shq_nx  = {shq[W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle DIV/DIVU sequencer for EX; MULT/MULTU join the iterative path when
// MULDIV_ITER_MUL_EN is defined, otherwise they are rejected and left to EX.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int DATA_W = muldiv_pkg::DATA_W,
    parameter int CNT_W  = muldiv_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              annul,
    input  logic              hold,
    output logic              busy,
    output logic              stallreq,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_hi,
    output logic [DATA_W-1:0] res_lo,
    output logic              div_by_zero
);

    muldiv_state_e state, state_nx;

    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   part, shq, opnd;
    logic                mul_mode, neg_lo, neg_hi;
    logic [DATA_W-1:0]   part_nx, shq_nx;
    logic [DATA_W-1:0]   a_mag, b_mag;
    logic [2*DATA_W-1:0] prod, prod_s;
    logic                accepted, signed_op, is_zero_div, last;

`ifdef MULDIV_ITER_MUL_EN
    assign accepted = 1'b1;
`else
    assign accepted = !op[1];
`endif

    assign signed_op   = !op[0];
    assign a_mag       = (signed_op && src_a[DATA_W-1]) ? -src_a : src_a;
    assign b_mag       = (signed_op && src_b[DATA_W-1]) ? -src_b : src_b;
    assign is_zero_div = !op[1] && (src_b == '0);
    assign last        = (cnt == CNT_W'(DATA_W - 1));

    muldiv_step #(.W(DATA_W)) u_step (
        .part     (part),
        .shq      (shq),
        .opnd     (opnd),
        .mul_mode (mul_mode),
        .part_nx  (part_nx),
        .shq_nx   (shq_nx)
    );

    assign prod   = {part_nx, shq_nx};
    assign prod_s = neg_lo ? -prod : prod;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start && !annul && accepted) state_nx = is_zero_div ? ZERO : RUN;
            ZERO:    state_nx = DONE;
            RUN:     if (last) state_nx = DONE;
            DONE:    if (!hold) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (annul) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            part        <= '0;
            shq         <= '0;
            opnd        <= '0;
            mul_mode    <= 1'b0;
            neg_lo      <= 1'b0;
            neg_hi      <= 1'b0;
            res_hi      <= '0;
            res_lo      <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_nx;
            if (annul) begin
                cnt <= '0;
            end else begin
                case (state)
                    IDLE: if (start && accepted) begin
                        // multiplier goes through shq so its low bit steers each add
                        cnt         <= '0;
                        part        <= '0;
                        div_by_zero <= 1'b0;
                        mul_mode    <= op[1];
                        shq         <= op[1] ? b_mag : a_mag;
                        opnd        <= op[1] ? a_mag : b_mag;
                        neg_lo      <= signed_op && (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
                        neg_hi      <= signed_op && src_a[DATA_W-1];
                    end
                    ZERO: begin
                        res_hi      <= '0;
                        res_lo      <= '0;
                        div_by_zero <= 1'b1;
                    end
                    RUN: begin
                        part <= part_nx;
                        shq  <= shq_nx;
                        cnt  <= cnt + CNT_W'(1);
                        if (last) begin
                            if (mul_mode) begin
                                res_hi <= prod_s[2*DATA_W-1:DATA_W];
                                res_lo <= prod_s[DATA_W-1:0];
                            end else begin
                                res_hi <= neg_hi ? -part_nx : part_nx;
                                res_lo <= neg_lo ? -shq_nx : shq_nx;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy      = (state != IDLE);
    assign res_valid = (state == DONE);
    assign stallreq  = ((state == IDLE) && start && !annul && accepted)
                     || (state == ZERO) || (state == RUN);

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed + randomized bench for muldiv_seq against an arithmetic reference model.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    logic        clk, rst, start, annul, hold;
    logic [1:0]  op;
    logic [31:0] src_a, src_b;
    logic        busy, stallreq, res_valid, div_by_zero;
    logic [31:0] res_hi, res_lo;

    int n_vec = 0;
    int n_err = 0;

    muldiv_seq dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .annul(annul), .hold(hold), .busy(busy), .stallreq(stallreq),
        .res_valid(res_valid), .res_hi(res_hi), .res_lo(res_lo), .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {div_by_zero, hi, lo} from plain arithmetic
    function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int     sa, sb;
        longint p;
        logic [63:0] up;
        sa = a;
        sb = b;
        case (o)
            OP_DIVU: return (b == 0) ? {1'b1, 64'd0} : {1'b0, a % b, a / b};
            OP_DIV: begin
                if (b == 0) return {1'b1, 64'd0};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'd0, 32'h8000_0000};
                return {1'b0, 32'(sa % sb), 32'(sa / sb)};
            end
            OP_MULT: begin
                p = longint'(sa) * longint'(sb);
                return {1'b0, 64'(p)};
            end
            default: begin
                up = {32'd0, a} * {32'd0, b};
                return {1'b0, up};
            end
        endcase
    endfunction

    function automatic bit is_accepted(input logic [1:0] o);
`ifdef MULDIV_ITER_MUL_EN
        return 1'b1;
`else
        return !o[1];
`endif
    endfunction

    // Entered one tick after a posedge; returns one tick after the posedge where the FSM is IDLE again.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int hold_n);
        logic [64:0] exp;
        int lat, exp_lat;
        bit acc;
        exp = model(o, a, b);
        acc = is_accepted(o);
        start = 1'b1; op = o; src_a = a; src_b = b;
        #1;
        chk({tag, ".stall_T"}, 64'(stallreq), 64'(acc));
        @(posedge clk); #1;
        start = 1'b0;
        if (!acc) begin
            chk({tag, ".busy_rej"}, 64'(busy), 64'd0);
            return;
        end
        exp_lat = exp[64] ? 2 : 33;
        lat = 1;
        while (res_valid !== 1'b1 && lat < 60) begin
            if (stallreq !== 1'b1) chk({tag, ".stall_run"}, 64'(stallreq), 64'd1);
            step();
            lat++;
        end
        chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, ".stall_done"}, 64'(stallreq), 64'd0);
        chk({tag, ".hilo"}, {res_hi, res_lo}, exp[63:0]);
        chk({tag, ".dbz"}, 64'(div_by_zero), 64'(exp[64]));
        hold = (hold_n > 0);
        for (int i = 0; i < hold_n; i++) begin
            step();
            if (i == hold_n - 1) hold = 1'b0;
            chk({tag, ".hold_vld"}, 64'(res_valid), 64'd1);
            chk({tag, ".hold_hilo"}, {res_hi, res_lo}, exp[63:0]);
        end
        step();
        chk({tag, ".idle"}, {62'd0, busy, res_valid}, 64'd0);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        rst = 1'b1; start = 1'b0; annul = 1'b0; hold = 1'b0;
        op = 2'b00; src_a = '0; src_b = '0;
        step();
        step();
        chk("reset.ctl", {60'd0, busy, stallreq, res_valid, div_by_zero}, 64'd0);
        chk("reset.hilo", {res_hi, res_lo}, 64'd0);
        rst = 1'b0;
        step();

        do_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 0);
        do_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 0);
        do_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op("divu_5_0", OP_DIVU, 32'd5, 32'd0, 0);
        do_op("div_neg_0", OP_DIV, 32'hFFFF_FF00, 32'd0, 1);
        do_op("divu_20_6_hold", OP_DIVU, 32'd20, 32'd6, 3);
        do_op("mult_m1_2", OP_MULT, 32'hFFFF_FFFF, 32'd2, 0);
        do_op("multu_big", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

        // abort mid-run, then a fresh op must complete normally
        start = 1'b1; op = OP_DIVU; src_a = 32'd1000; src_b = 32'd3;
        step();
        start = 1'b0;
        for (int i = 0; i < 9; i++) step();
        annul = 1'b1;
        step();
        annul = 1'b0;
        chk("annul.idle", {62'd0, busy, res_valid}, 64'd0);
        step();
        chk("annul.no_result", 64'(res_valid), 64'd0);
        do_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, 0);

        // start coincident with annul is ignored
        start = 1'b1; annul = 1'b1; op = OP_DIVU; src_a = 32'd7; src_b = 32'd1;
        #1;
        chk("annul_start.stall", 64'(stallreq), 64'd0);
        step();
        start = 1'b0; annul = 1'b0;
        chk("annul_start.busy", 64'(busy), 64'd0);

        // reset mid-run clears everything
        start = 1'b1; op = OP_DIVU; src_a = 32'd77; src_b = 32'd5;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid.ctl", {60'd0, busy, stallreq, res_valid, div_by_zero}, 64'd0);
        chk("rst_mid.hilo", {res_hi, res_lo}, 64'd0);
        step();

        for (int i = 0; i < 16; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 20));
                2:       rb = -32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            do_op("rand", ro, ra, rb, int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
